shift_reg_seq: RTL and testbench

//  Iterative shift unit sitting directly downstream of mux_shiftN: takes the 5-bit

---
 rtl/shift_reg_seq_pkg.sv | 22 ++
 rtl/shift_reg_seq_step.sv | 24 ++
 rtl/shift_reg_seq.sv | 91 +++++++++
 tb/tb_shift_reg_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/shift_reg_seq_pkg.sv
// Shared definitions for the iterative shift unit: widths, opcodes and FSM encodings.
package shift_reg_seq_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_reg_seq_step.sv
// Single-bit shift/rotate step; LOAD and the reserved opcodes pass data through.
module shift_reg_seq_step
    import shift_reg_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] d,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SLL:  q = {d[DATA_W-2:0], 1'b0};
            OP_SRL:  q = {1'b0, d[DATA_W-1:1]};
            OP_SRA:  q = {d[DATA_W-1], d[DATA_W-1:1]};
            OP_ROL:  q = {d[DATA_W-2:0], d[DATA_W-1]};
            OP_ROR:  q = {d[0], d[DATA_W-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Multicycle shift unit: loads an operand on start, shifts one position per clock,
// then pulses done for one cycle and holds the result until the next start.
module shift_reg_seq
    import shift_reg_seq_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W   // 2**SHAMT_W must equal DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         shift_op,
    input  logic [SHAMT_W-1:0] n_in,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    // Handshake: start is honoured only while IDLE (busy low); once accepted the
    // inputs are copied, further starts are ignored until done has pulsed and
    // the unit is back in IDLE. done marks the single cycle data_out is final.

    state_e             state_q, state_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic [SHAMT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]         op_q, op_nxt;
    logic [DATA_W-1:0]  step_out;
    logic               busy_q, done_q;

    shift_reg_seq_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_out)
    );

    always_comb begin
        state_nxt = state_q;
        data_nxt  = data_q;
        cnt_nxt   = cnt_q;
        op_nxt    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SHIFT;
                    data_nxt  = data_in;
                    cnt_nxt   = n_in;
                    op_nxt    = shift_op;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    data_nxt = step_out;
                    cnt_nxt  = cnt_q - SHAMT_W'(1);
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // busy/done come straight from flops, computed from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            data_q  <= data_nxt;
            cnt_q   <= cnt_nxt;
            op_q    <= op_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
            done_q  <= (state_nxt == ST_DONE);
        end
    end

    assign data_out  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq: hand-computed results, latency and handshake checks.
module tb_shift_reg_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  shift_op;
    logic [4:0]  n_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    int          total;
    int          bad;

    shift_reg_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .shift_op  (shift_op),
        .n_in      (n_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    // driver: called at a negedge, start is sampled at the following posedge
    task automatic issue(input logic [2:0] op, input logic [4:0] n, input logic [31:0] d,
                         input logic [31:0] exp);
        start    = 1'b1;
        shift_op = op;
        n_in     = n;
        data_in  = d;
        exp_q.push_back(exp);
        last_exp = exp;
    endtask

    task automatic wait_done(input string tag, input int n, input bit hammer);
        int  i;
        bit  seen;
        seen = 1'b0;
        for (i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!hammer) start = 1'b0;
            shift_op = 3'($urandom_range(0, 7));
            n_in     = 5'($urandom_range(0, 31));
            data_in  = $urandom;
            if (i == 0) check_eq({tag, "_busy_on"}, {31'd0, busy}, 32'd1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq({tag, "_latency"}, i, n + 1);
        check_eq({tag, "_result"}, data_out, exp_q.pop_front());
        if (seen) check_eq({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic post_idle(input string tag);
        @(negedge clk);
        check_eq({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_state_idle"}, {30'd0, state_dbg}, 32'd0);
        check_eq({tag, "_hold"}, data_out, last_exp);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [4:0] n,
                       input logic [31:0] d, input logic [31:0] exp);
        issue(op, n, d, exp);
        wait_done(tag, int'(n), 1'b0);
        post_idle(tag);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        last_exp = '0;
        reset    = 1'b0;
        start    = 1'b0;
        shift_op = 3'b000;
        n_in     = 5'd0;
        data_in  = 32'h0;

        repeat (2) @(negedge clk);
        check_eq("rst_data", data_out, 32'h0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_state", {30'd0, state_dbg}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // directed vectors
        run("sll4",  3'b001, 5'd4,  32'h0000_0001, 32'h0000_0010);
        run("sra31", 3'b011, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        run("srl31", 3'b010, 5'd31, 32'h8000_0000, 32'h0000_0001);
        run("ror4",  3'b101, 5'd4,  32'h0000_000F, 32'hF000_0000);
        run("rol1",  3'b100, 5'd1,  32'h8000_0001, 32'h0000_0003);
        run("sll0",  3'b001, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run("load7", 3'b000, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run("rsv3",  3'b110, 5'd3,  32'h1234_5678, 32'h1234_5678);
        run("sll31", 3'b001, 5'd31, 32'h0000_0001, 32'h8000_0000);
        run("srl5",  3'b010, 5'd5,  32'hF000_0000, 32'h0780_0000);

        // start held high throughout: one done, restart only from IDLE
        issue(3'b001, 5'd3, 32'h0000_0001, 32'h0000_0008);
        wait_done("hammer", 3, 1'b1);
        post_idle("hammer");
        issue(3'b001, 5'd1, 32'h0000_0003, 32'h0000_0006);
        wait_done("restart", 1, 1'b0);
        post_idle("restart");

        // reset in the middle of SLL N=20
        issue(3'b001, 5'd20, 32'h0000_0001, 32'h0010_0000);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        check_eq("mid_state", {30'd0, state_dbg}, 32'd1);
        reset = 1'b0;
        #1;
        check_eq("arst_data", data_out, 32'h0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_state", {30'd0, state_dbg}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("arst_no_done", {31'd0, done}, 32'd0);
        end
        void'(exp_q.pop_front());
        reset = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check_eq("post_rst_no_done", {31'd0, done}, 32'd0);
        end
        check_eq("post_rst_data", data_out, 32'h0);

        run("after_rst", 3'b011, 5'd2, 32'h8000_0010, 32'hE000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
